// File: rtl/zbuf_addr_arbiter_if.sv
// ----------------------------------------------------------------------------
// zbuf_addr_arbiter_if
// Bundles the handshake and data signals around zbuf_addr_arbiter:
//   req0_* / req1_* : fragment requests from the two rasterizer lanes
//   calc_*          : issue and return sides of the shared zbuf_addr_calc
//   res0_* / res1_* : per-lane address results toward the z-buffer read stage
// Modports:
//   slave  : the arbiter's view (consumes requests, drives calc and results)
//   master : the surrounding system's view (lanes, calc unit, consumers)
// ----------------------------------------------------------------------------
interface zbuf_addr_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req0_nd;
    logic              req0_rfd;
    logic [15:0]       req0_x;
    logic [15:0]       req0_y;
    logic              req1_nd;
    logic              req1_rfd;
    logic [15:0]       req1_x;
    logic [15:0]       req1_y;

    logic              calc_nd;
    logic              calc_us_rfd;
    logic [15:0]       calc_fp_x;
    logic [15:0]       calc_fp_y;
    logic              calc_rdy;
    logic              calc_ds_rfd;
    logic [ADDR_W-1:0] calc_addr;

    logic              res0_rdy;
    logic              res0_ds_rfd;
    logic [ADDR_W-1:0] res0_addr;
    logic              res1_rdy;
    logic              res1_ds_rfd;
    logic [ADDR_W-1:0] res1_addr;

    modport slave (
        input  req0_nd, req0_x, req0_y, req1_nd, req1_x, req1_y,
        input  calc_us_rfd, calc_rdy, calc_addr,
        input  res0_ds_rfd, res1_ds_rfd,
        output req0_rfd, req1_rfd,
        output calc_nd, calc_fp_x, calc_fp_y, calc_ds_rfd,
        output res0_rdy, res0_addr, res1_rdy, res1_addr
    );

    modport master (
        output req0_nd, req0_x, req0_y, req1_nd, req1_x, req1_y,
        output calc_us_rfd, calc_rdy, calc_addr,
        output res0_ds_rfd, res1_ds_rfd,
        input  req0_rfd, req1_rfd,
        input  calc_nd, calc_fp_x, calc_fp_y, calc_ds_rfd,
        input  res0_rdy, res0_addr, res1_rdy, res1_addr
    );
endinterface

// File: rtl/zbuf_addr_arbiter.sv
// ----------------------------------------------------------------------------
// zbuf_addr_arbiter
// Shares one zbuf_addr_calc between two rasterizer lanes. Input slots are
// granted round-robin (lane 0 wins the first contention after reset), the
// owning lane of every in-flight request is pushed into a tag FIFO, and each
// returned address is steered to the lane at the FIFO head, in issue order.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   bus         : zbuf_addr_arbiter_if.slave (lane requests, calc unit, results)
//   err         : sticky flag, set when calc_rdy arrives with no tag in flight
//   grant_cnt0/1: saturating per-lane grant counters
// Build option:
//   ZBUF_ARB_STATS_EN defined   -> grant counters are built
//   ZBUF_ARB_STATS_EN undefined -> grant_cnt0/1 tie to 0, no counter flops
// ----------------------------------------------------------------------------
module zbuf_addr_arbiter #(
    parameter int unsigned TAG_DEPTH = 8,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    zbuf_addr_arbiter_if.slave        bus,
    output logic                      err,
    output logic [15:0]               grant_cnt0,
    output logic [15:0]               grant_cnt1
);
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(TAG_DEPTH);

    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [TAG_DEPTH-1:0] tag_q, tag_d;
    logic                 last_grant_q, last_grant_d;
    logic                 err_q, err_d;

    logic              any_nd, grant, can_issue, issue;
    logic              not_empty, head, ds_rfd, pop;
    logic [ADDR_W-1:0] addr_ret;

    // Issue side: fully combinational, every handshake output forced low in reset.
    always_comb begin
        any_nd    = bus.req0_nd | bus.req1_nd;
        grant     = (bus.req0_nd & bus.req1_nd) ? ~last_grant_q : bus.req1_nd;
        // A full FIFO blocks issue even when a pop happens this cycle, so no
        // path exists from the consumer rfd inputs to the lane rfd outputs.
        can_issue = ~rst & bus.calc_us_rfd & (count_q != FULL);
        issue     = can_issue & any_nd;
        not_empty = (count_q != '0);
        head      = tag_q[rd_ptr_q];
        ds_rfd    = ~rst & not_empty & (head ? bus.res1_ds_rfd : bus.res0_ds_rfd);
        pop       = bus.calc_rdy & ds_rfd;
    end

    assign bus.req0_rfd    = can_issue & any_nd & ~grant;
    assign bus.req1_rfd    = can_issue & any_nd & grant;
    assign bus.calc_nd     = issue;
    assign bus.calc_fp_x   = (any_nd & grant) ? bus.req1_x : bus.req0_x;
    assign bus.calc_fp_y   = (any_nd & grant) ? bus.req1_y : bus.req0_y;
    assign bus.calc_ds_rfd = ds_rfd;

    assign addr_ret        = bus.calc_addr;
    assign bus.res0_addr   = addr_ret;
    assign bus.res1_addr   = addr_ret;
    assign bus.res0_rdy    = ~rst & bus.calc_rdy & not_empty & ~head;
    assign bus.res1_rdy    = ~rst & bus.calc_rdy & not_empty & head;
    assign err             = err_q;

    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tag_d        = tag_q;
        last_grant_d = last_grant_q;
        err_d        = err_q | (bus.calc_rdy & ~not_empty);
        if (issue) begin
            tag_d[wr_ptr_q] = grant;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            last_grant_d    = grant;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({issue, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_q        <= '0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_q        <= tag_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

`ifdef ZBUF_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (issue & ~grant & (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
        if (issue & grant & (cnt1_q != '1))  cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif
endmodule

// File: doc/zbuf_addr_arbiter.md
Name: zbuf_addr_arbiter

Overview:
- Shares one zbuf_addr_calc instance between two rasterizer fragment lanes (requester 0 and requester 1).
- Grants input slots round-robin and records the owner of each in-flight request in a tag FIFO.
- Steers each computed z-buffer address back to its owning lane, in issue order.
- Sits between the two triangle-rasterizer edge walkers and the z-buffer read stage.

Parameters:
- TAG_DEPTH, 8: maximum requests in flight inside zbuf_addr_calc; power of 2, min 2.
- ADDR_W, 32: width of zbuf_addr_calc result address.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_nd  in  1  lane 0 has a fragment.
- req0_rfd  out  1  lane 0 fragment accepted this cycle when high with req0_nd.
- req0_x  in  16  lane 0 fp16 x.
- req0_y  in  16  lane 0 fp16 y.
- req1_nd, req1_rfd, req1_x, req1_y: same as lane 0, for lane 1.
- calc_nd  out  1  drives zbuf_addr_calc nd.
- calc_us_rfd  in  1  zbuf_addr_calc us_rfd.
- calc_fp_x  out  16  drives zbuf_addr_calc fp_x.
- calc_fp_y  out  16  drives zbuf_addr_calc fp_y.
- calc_rdy  in  1  zbuf_addr_calc rdy.
- calc_ds_rfd  out  1  drives zbuf_addr_calc ds_rfd.
- calc_addr  in  ADDR_W  zbuf_addr_calc zbuff_addr.
- res0_rdy  out  1  lane 0 result valid.
- res0_ds_rfd  in  1  lane 0 consumer ready.
- res0_addr  out  ADDR_W  lane 0 address.
- res1_rdy, res1_ds_rfd, res1_addr: same as lane 0, for lane 1.
- err  out  1  sticky protocol error.
- grant_cnt0  out  16  lane 0 grant count (see Optional Feature).
- grant_cnt1  out  16  lane 1 grant count (see Optional Feature).

Behaviour:
- Reset (rst high at a clk edge): FIFO count = 0, read/write pointers = 0, last_grant = 1 (lane 0 wins first contention), err = 0, counters = 0.
- While rst is high, every rfd/rdy/nd output is held at 0.
- Reset mid-operation discards all tags. The system resets zbuf_addr_calc on the same rst.
- Issue enable: can_issue = calc_us_rfd & (count != TAG_DEPTH).
- Grant is combinational:
  - Only one lane with nd: that lane is granted.
  - Both lanes with nd: the lane != last_grant is granted.
- reqN_rfd = can_issue & (grant == N). An rfd never asserts toward an idle lane.
- calc_nd = can_issue & (req0_nd | req1_nd).
- calc_fp_x/y mux the granted lane's x/y; they hold the lane 0 inputs when no lane is granted.
- Issue latency: 0 cycles, fully combinational pass-through.
- On an issue edge:
  - push the granted lane id into the tag FIFO;
  - last_grant <= granted lane.
- Return path, with head = FIFO head tag:
  - resN_rdy = calc_rdy & (count != 0) & (head == N).
  - resN_addr = calc_addr for both lanes (qualify with rdy).
  - calc_ds_rfd = (count != 0) & res_head_ds_rfd.
  - A result transfers when calc_rdy & calc_ds_rfd; the tag pops on that edge.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Full FIFO blocks issue even if a pop occurs the same cycle; this avoids any rfd-to-rfd combinational path.
- Pointers wrap modulo TAG_DEPTH.
- calc_rdy high while count == 0 is a protocol error:
  - err <= 1 and stays set until rst;
  - no pop; calc_ds_rfd stays 0.
- Ordering: results leave in issue order. A stalled head lane blocks the other lane's results; this is head-of-line blocking by design.

Optional Feature:
- Macro: ZBUF_ARB_STATS_EN.
- Defined: grant_cnt0/1 increment on each issue edge for their lane. They saturate at 16'hFFFF and clear on rst.
- Undefined: grant_cnt0/1 are constant 0 and no counter flops are built.
- No other behaviour differs between the two builds.

Test Plan:
- Reset, then lane 0 only: req0_nd=1, x=16'h3C00, y=16'h3C00, calc_us_rfd=1 → req0_rfd=1 the same cycle, calc_fp_x=16'h3C00, req1_rfd=0. Later calc_rdy with addr 32'h00000101 → res0_rdy=1, res1_rdy=0.
- Contention: both nd held for 4 cycles, calc_us_rfd=1 → grants 0,1,0,1; tag FIFO holds 0,1,0,1. Returns route to res0, res1, res0, res1 in that order.
- Backpressure: hold calc_rdy=0 and issue 8 requests → count=8, the 9th cycle shows req0_rfd=req1_rfd=0. One pop → issue resumes the next cycle.
- Head-of-line: head tag = 1, res1_ds_rfd=0, res0_ds_rfd=1, calc_rdy=1 → calc_ds_rfd=0 and no pop. Raise res1_ds_rfd → pop, res1 takes the address.
- Error and reset: calc_rdy=1 with an empty FIFO → err=1 the next cycle and stays set. Pulse rst during 3 in-flight requests → count=0, err=0, and lane 0 is granted first afterwards.
- ZBUF_ARB_STATS_EN build: 5 lane 0 grants and 3 lane 1 grants → grant_cnt0=5, grant_cnt1=3. Undefined build → both read 0.
